// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: single-transfer Wishbone-style reads from instruction memory,
// registered handoff to the decoder, PC ownership with redirects and a bus timeout.
module inst_fetch #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned INST_W  = 18,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_en_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic              inst_cyc_o,
    output logic              inst_stb_o,
    output logic [ADDR_W-1:0] inst_adr_o,
    input  logic              inst_ack_i,
    input  logic [INST_W-1:0] inst_dat_i,
    output logic [INST_W-1:0] inst_o,
    output logic              ack_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              fault_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StFault} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] adr_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic [ADDR_W-1:0] redir_addr_q;
    logic [INST_W-1:0] inst_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cyc_q;
    logic              ack_q;
    logic              busy_q;
    logic              fault_q;
    logic              redir_pend_q;

    // A redirect arriving in the ack cycle counts the same as one latched earlier.
    logic              redir_any;
    logic [ADDR_W-1:0] redir_target;

    assign redir_any    = redir_pend_q | redirect_i;
    assign redir_target = redirect_i ? redirect_addr_i : redir_addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            adr_q        <= '0;
            pc_out_q     <= '0;
            redir_addr_q <= '0;
            inst_q       <= '0;
            cnt_q        <= '0;
            cyc_q        <= 1'b0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            redir_pend_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (redirect_i) begin
                        pc_q <= redirect_addr_i;
                    end else if (fetch_en_i) begin
                        cyc_q        <= 1'b1;
                        adr_q        <= pc_q;
                        cnt_q        <= '0;
                        redir_pend_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= StFetch;
                    end
                end
                StFetch: begin
                    if (inst_ack_i) begin
                        cyc_q        <= 1'b0;
                        busy_q       <= 1'b0;
                        redir_pend_q <= 1'b0;
                        state_q      <= StIdle;
                        if (redir_any) begin
                            pc_q <= redir_target;
                        end else begin
                            inst_q   <= inst_dat_i;
                            pc_out_q <= adr_q;
                            ack_q    <= 1'b1;
                            pc_q     <= pc_q + 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        cyc_q        <= 1'b0;
                        fault_q      <= 1'b1;
                        redir_pend_q <= 1'b0;
                        state_q      <= StFault;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (redirect_i) begin
                            redir_pend_q <= 1'b1;
                            redir_addr_q <= redirect_addr_i;
                        end
                    end
                end
                StFault: begin
                    if (redirect_i) begin
                        fault_q <= 1'b0;
                        pc_q    <= redirect_addr_i;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign inst_cyc_o = cyc_q;
    assign inst_stb_o = cyc_q;
    assign inst_adr_o = adr_q;
    assign inst_o     = inst_q;
    assign ack_o      = ack_q;
    assign pc_o       = pc_out_q;
    assign busy_o     = busy_q;
    assign fault_o    = fault_q;

endmodule
